packet_transmit_buffer: RTL
===========================

Name: packet_transmit_buffer

Overview:
- Packet source feeding the neuromorphic core's input-buffer interface. It is the transmit side that pairs with the test receive block.
- A host or test sequencer pushes packets through a valid/ready write port. The core pops them through `ren` and sees them on `packet` / `input_buffer_empty`.
- Implemented as a first-word-fall-through circular FIFO, with an occupancy count and sticky overflow/underflow error flags.

Parameters:
- PACKET_WIDTH, 32, width of one packet in bits.
- DEPTH, 16, number of FIFO entries. Must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1, width of the count output. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_packet  in  PACKET_WIDTH  packet offered by the host.
- wr_valid  in  1  host offers wr_packet this cycle.
- wr_ready  out  1  buffer can accept a packet.
- packet  out  PACKET_WIDTH  head-of-FIFO packet presented to the core.
- input_buffer_empty  out  1  FIFO holds no packets.
- ren  in  1  core pops the head packet this cycle.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky: a write was attempted while full.
- underflow_err  out  1  sticky: a read was attempted while empty.
- clear_err  in  1  clears both sticky error flags.

Behaviour:
- State: storage array mem[DEPTH], wr_ptr and rd_ptr (log2 DEPTH bits each), count register.
- Pointers wrap naturally modulo DEPTH.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0.
  - input_buffer_empty=1, wr_ready=1, packet=0.
  - overflow_err=0, underflow_err=0.
  - mem contents are not reset.
- Reset asserted mid-operation discards all stored packets on that edge. wr_valid and ren are ignored during that cycle.
- Decoded flags from the registered count, no extra latency:
  - input_buffer_empty = (count==0).
  - full = (count==DEPTH).
  - wr_ready = !full.
- Write accept: `wr_valid & wr_ready`. Stores wr_packet at mem[wr_ptr], then wr_ptr+1.
- Read accept: `ren & !input_buffer_empty`. rd_ptr+1. The popped packet is the one shown on `packet` in the same cycle.
- Output `packet`:
  - mem[rd_ptr] combinationally whenever non-empty.
  - Forced to all-zero when empty.
  - A packet written into an empty FIFO appears on `packet` the cycle after the write edge (write-to-visible latency of 1 cycle).
- Count update on each edge:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - unchanged when both accept or neither.
- Simultaneous write and read:
  - Full FIFO: wr_ready=0, so only the read happens and the write is rejected. overflow_err sets if wr_valid=1. Count drops to DEPTH-1.
  - Empty FIFO: only the write happens. The read is an underflow and sets underflow_err. Count becomes 1. The new packet does not bypass to `packet` in the same cycle.
  - 0<count<DEPTH: both happen and count is unchanged.
- Rejected write (wr_valid & !wr_ready): packet is dropped, no state change apart from overflow_err<=1.
- Rejected read (ren & empty): no pointer or count change; underflow_err<=1.
- clear_err=1 clears both flags on the next edge. If a new error event occurs in the same cycle, set wins over clear.
- No combinational path from ren or wr_valid to any output.

Test Plan:
1. Assert rst for 2 cycles → input_buffer_empty=1, wr_ready=1, count=0, packet=0x00000000, both error flags 0.
2. Write 0xA0000001..0xA0000010 (16 packets) on consecutive cycles → count=16, wr_ready=0 after the 16th. Then offer 0xDEADBEEF → overflow_err=1, count stays 16. Pop 16 times → packets appear in order 0xA0000001..0xA0000010, then input_buffer_empty=1.
3. With count=3, assert wr_valid and ren together for 5 cycles → count stays 3, read order is preserved, no error flags set.
4. On an empty FIFO, assert ren together with a wr_valid of 0x12345678 → underflow_err=1, count=1, packet=0x12345678 on the following cycle.
5. Write and read 40 packets, keeping count ≤ 4 → both pointers wrap twice and the data sequence comes out intact. Pulse clear_err → both flags 0 the next cycle. clear_err asserted together with ren on an empty FIFO → underflow_err stays 1.
6. Assert rst while count=7 → next cycle count=0, input_buffer_empty=1, packet=0, errors 0. The following write/read round-trip works normally.

Source files
------------

// File: rtl/packet_transmit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : packet_transmit_buffer
// Description : First-word-fall-through packet FIFO feeding the core's input
//               buffer, with occupancy count and sticky over/underflow flags.
// Revision    : 1.0
// ============================================================================
module packet_transmit_buffer #(
    parameter int PACKET_WIDTH = 32,
    parameter int DEPTH        = 16,
    parameter int CW           = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] wr_packet,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [PACKET_WIDTH-1:0] packet,
    output logic                    input_buffer_empty,
    input  logic                    ren,
    output logic [CW-1:0]           count,
    output logic                    overflow_err,
    output logic                    underflow_err,
    input  logic                    clear_err
);

    localparam int AW = $clog2(DEPTH);

    logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_overflow_err;
    logic                    r_underflow_err;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags decode straight from the registered count so ren/wr_valid never
    // reach an output combinationally.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_valid & ~w_full;
    assign w_rd_acc = ren & ~w_empty;

    assign wr_ready           = ~w_full;
    assign input_buffer_empty = w_empty;
    assign count              = r_count;
    assign overflow_err       = r_overflow_err;
    assign underflow_err      = r_underflow_err;
    assign packet             = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_packet;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
            // A fresh error event in the same cycle wins over clear_err.
            r_overflow_err  <= (wr_valid & w_full) | (r_overflow_err & ~clear_err);
            r_underflow_err <= (ren & w_empty) | (r_underflow_err & ~clear_err);
        end
    end

endmodule
`default_nettype wire
